// File: rtl/tmds_ddr_serializer.sv
// TMDS 10:1 serializer feeding four ODDRX1F cells (three data lanes + clock lane).
// Runs in the 5x shift clock. A 5-phase counter sets the pixel-rate load slot.
module tmds_ddr_serializer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [29:0] i_sym_data,
    input  logic        i_sym_valid,
    output logic        o_sym_ready,
    output logic        o_pixel_tick,
    output logic [3:0]  o_ddr_d0,
    output logic [3:0]  o_ddr_d1,
    output logic [15:0] o_underflow_cnt,
    input  logic        i_underflow_clr
);

    localparam logic [9:0] IDLE_SYMBOL   = 10'b1101010100;
    localparam logic [9:0] CLOCK_PATTERN = 10'b0000011111;

    logic [2:0]       r_phase;
    logic [3:0][9:0]  r_word;
    logic [3:0]       r_d0;
    logic [3:0]       r_d1;
    logic [15:0]      r_underflow_cnt;

    logic             w_slot;
    logic             w_xfer;
    logic             w_under;
    logic [3:0]       w_idx_lo;
    logic [3:0]       w_idx_hi;
    logic [2:0]       w_phase_next;
    logic [3:0][9:0]  w_word_next;
    logic [3:0]       w_d0_next;
    logic [3:0]       w_d1_next;
    logic [15:0]      w_cnt_next;

    assign w_slot   = (r_phase == 3'd4);
    assign w_xfer   = w_slot & i_en & i_sym_valid;
    assign w_under  = w_slot & i_en & ~i_sym_valid;
    // Each phase emits one bit pair: bits [2*phase+1 : 2*phase].
    assign w_idx_lo = {r_phase, 1'b0};
    assign w_idx_hi = {r_phase, 1'b1};

    // Next-state logic for phase, symbol word, output bits and underflow counter.
    always_comb begin
        w_phase_next = r_phase + 3'd1;
        w_word_next  = r_word;
        w_d0_next    = 4'b0000;
        w_d1_next    = 4'b0000;
        w_cnt_next   = r_underflow_cnt;

        if (r_phase >= 3'd4) begin
            w_phase_next = 3'd0;
        end else begin
            w_phase_next = r_phase + 3'd1;
        end

        if (w_slot) begin
            w_word_next[3] = CLOCK_PATTERN;
            if (w_xfer) begin
                w_word_next[2] = i_sym_data[29:20];
                w_word_next[1] = i_sym_data[19:10];
                w_word_next[0] = i_sym_data[9:0];
            end else begin
                w_word_next[2] = IDLE_SYMBOL;
                w_word_next[1] = IDLE_SYMBOL;
                w_word_next[0] = IDLE_SYMBOL;
            end
        end else begin
            w_word_next = r_word;
        end

        for (int l = 0; l < 4; l++) begin
            w_d0_next[l] = r_word[l][w_idx_lo];
            w_d1_next[l] = r_word[l][w_idx_hi];
        end

        // Clear takes priority over a same-edge underflow increment.
        if (i_underflow_clr) begin
            w_cnt_next = 16'h0000;
        end else if (w_under && (r_underflow_cnt != 16'hFFFF)) begin
            w_cnt_next = r_underflow_cnt + 16'h0001;
        end else begin
            w_cnt_next = r_underflow_cnt;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase         <= 3'd0;
            r_word          <= {CLOCK_PATTERN, IDLE_SYMBOL, IDLE_SYMBOL, IDLE_SYMBOL};
            r_d0            <= 4'b0000;
            r_d1            <= 4'b0000;
            r_underflow_cnt <= 16'h0000;
        end else begin
            r_phase         <= w_phase_next;
            r_word          <= w_word_next;
            r_d0            <= w_d0_next;
            r_d1            <= w_d1_next;
            r_underflow_cnt <= w_cnt_next;
        end
    end

    assign o_pixel_tick    = w_slot;
    assign o_sym_ready     = w_slot & i_en;
    assign o_ddr_d0        = r_d0;
    assign o_ddr_d1        = r_d1;
    assign o_underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// Directed self-checking bench for tmds_ddr_serializer.
// The bench tracks the phase and rebuilds each lane's 10-bit symbol from the DDR bit pairs.
module tb_tmds_ddr_serializer;

    localparam logic [9:0] IDLE = 10'b1101010100;
    localparam logic [9:0] CLKP = 10'b0000011111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [29:0] sym_data = 30'h0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic        pixel_tick;
    logic [3:0]  ddr_d0;
    logic [3:0]  ddr_d1;
    logic [15:0] underflow_cnt;
    logic        underflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int tb_ph  = 0;
    logic [39:0] cap = 40'h0;
    logic [39:0] rx_q[$];
    logic [39:0] idle_word;

    tmds_ddr_serializer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_en            (en),
        .i_sym_data      (sym_data),
        .i_sym_valid     (sym_valid),
        .o_sym_ready     (sym_ready),
        .o_pixel_tick    (pixel_tick),
        .o_ddr_d0        (ddr_d0),
        .o_ddr_d1        (ddr_d1),
        .o_underflow_cnt (underflow_cnt),
        .i_underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Advance one clock and collect the bit pair emitted for the phase just left.
    task automatic step();
        int p;
        p = tb_ph;
        @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            cap[10*l + 2*p]     = ddr_d0[l];
            cap[10*l + 2*p + 1] = ddr_d1[l];
        end
        if (p == 4) rx_q.push_back(cap);
        tb_ph = (p == 4) ? 0 : p + 1;
    endtask

    task automatic wait_slot();
        for (int i = 0; i < 6 && tb_ph != 4; i++) step();
    endtask

    task automatic model_reset();
        tb_ph = 0;
        cap = 40'h0;
        rx_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ddr_d0 !== 4'b0000) begin errors++; $display("FAIL reset_d0: got %b want 0000", ddr_d0); end
        checks++; if (ddr_d1 !== 4'b0000) begin errors++; $display("FAIL reset_d1: got %b want 0000", ddr_d1); end
        checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h want 0000", underflow_cnt); end
        checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sym_ready); end
        rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (ddr_d0 !== 4'b1000 || ddr_d1 !== 4'b1000) begin
            errors++; $display("FAIL first_pair: got d0=%b d1=%b want 1000/1000", ddr_d0, ddr_d1);
        end
        for (int c = 1; c < 15; c++) begin
            checks++; if (pixel_tick !== (tb_ph == 4)) begin
                errors++; $display("FAIL tick_cadence: cycle %0d got %b want %b", c, pixel_tick, (tb_ph == 4));
            end
            step();
        end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL reset_sym_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== idle_word) begin
                errors++; $display("FAIL reset_idle_clock: sym %0d got %h want %h", i, rx_q[i], idle_word);
            end
        end
    endtask

    task automatic test_single_transfer();
        int n0;
        en = 1'b1;
        wait_slot();
        n0 = rx_q.size();
        sym_valid = 1'b1;
        sym_data = {10'h3FF, 10'h000, 10'h2AA};
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", sym_ready); end
        step();
        sym_valid = 1'b0;
        sym_data = 30'h1555_4321;
        checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL single_no_uf: got %h want 0000", underflow_cnt); end
        repeat (5) step();
        checks++; if (underflow_cnt !== 16'h0001) begin errors++; $display("FAIL single_next_uf: got %h want 0001", underflow_cnt); end
        en = 1'b0;
        repeat (5) step();
        checks++; if (rx_q[n0] !== idle_word) begin errors++; $display("FAIL single_before: got %h want %h", rx_q[n0], idle_word); end
        checks++; if (rx_q[n0+1] !== {CLKP, 10'h3FF, 10'h000, 10'h2AA}) begin
            errors++; $display("FAIL single_data: got %h want %h", rx_q[n0+1], {CLKP, 10'h3FF, 10'h000, 10'h2AA});
        end
        checks++; if (rx_q[n0+2] !== idle_word) begin errors++; $display("FAIL single_after: got %h want %h", rx_q[n0+2], idle_word); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int k;
        int xfers;
        logic [29:0] base;
        base = 30'h0155_5000;
        k = 0;
        xfers = 0;
        en = 1'b1;
        wait_slot();
        n0 = rx_q.size();
        for (int c = 0; c < 30; c++) begin
            if (tb_ph == 4) begin
                sym_valid = 1'b1;
                sym_data = base + 30'(k);
                k++;
            end else begin
                sym_data = 30'h3FFF_FFFF ^ 30'(c);
            end
            if (sym_ready && sym_valid) xfers++;
            step();
        end
        en = 1'b0;
        sym_valid = 1'b0;
        repeat (5) step();
        checks++; if (xfers != 6) begin errors++; $display("FAIL b2b_xfers: got %0d want 6", xfers); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (rx_q[n0+1+i] !== {CLKP, base + 30'(i)}) begin
                errors++; $display("FAIL b2b_word: idx %0d got %h want %h", i, rx_q[n0+1+i], {CLKP, base + 30'(i)});
            end
        end
        checks++; if (underflow_cnt !== 16'h0001) begin errors++; $display("FAIL b2b_cnt: got %h want 0001", underflow_cnt); end
    endtask

    task automatic test_underflow();
        int n0;
        step();
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL uf_clear: got %h want 0000", underflow_cnt); end
        en = 1'b1;
        sym_valid = 1'b0;
        n0 = rx_q.size();
        repeat (15) step();
        en = 1'b0;
        repeat (5) step();
        checks++; if (underflow_cnt !== 16'h0003) begin errors++; $display("FAIL uf_count3: got %h want 0003", underflow_cnt); end
        for (int i = 1; i <= 3; i++) begin
            checks++; if (rx_q[n0+i] !== idle_word) begin
                errors++; $display("FAIL uf_idle: sym %0d got %h want %h", i, rx_q[n0+i], idle_word);
            end
        end
        force dut.r_underflow_cnt = 16'hFFFE;
        #1;
        release dut.r_underflow_cnt;
        en = 1'b1;
        repeat (15) step();
        en = 1'b0;
        checks++; if (underflow_cnt !== 16'hFFFF) begin errors++; $display("FAIL uf_saturate: got %h want FFFF", underflow_cnt); end
    endtask

    task automatic test_clear_race();
        en = 1'b1;
        sym_valid = 1'b0;
        wait_slot();
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL race_clear: got %h want 0000", underflow_cnt); end
        wait_slot();
        step();
        en = 1'b0;
        checks++; if (underflow_cnt !== 16'h0001) begin errors++; $display("FAIL race_next: got %h want 0001", underflow_cnt); end
    endtask

    task automatic test_disabled();
        int n0;
        int ticks;
        int bad_ready;
        en = 1'b0;
        sym_valid = 1'b1;
        sym_data = 30'h3FFF_FFFF;
        ticks = 0;
        bad_ready = 0;
        n0 = rx_q.size();
        for (int c = 0; c < 15; c++) begin
            if (sym_ready !== 1'b0) bad_ready++;
            if (pixel_tick === 1'b1) ticks++;
            step();
        end
        repeat (5) step();
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL dis_ready: got %0d cycles high want 0", bad_ready); end
        checks++; if (ticks != 3) begin errors++; $display("FAIL dis_ticks: got %0d want 3", ticks); end
        checks++; if (underflow_cnt !== 16'h0001) begin errors++; $display("FAIL dis_cnt: got %h want 0001", underflow_cnt); end
        for (int i = 1; i <= 3; i++) begin
            checks++; if (rx_q[n0+i] !== idle_word) begin
                errors++; $display("FAIL dis_idle: sym %0d got %h want %h", i, rx_q[n0+i], idle_word);
            end
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        sym_valid = 1'b1;
        sym_data = {10'h0F0, 10'h3C3, 10'h155};
        for (int i = 0; i < 8 && tb_ph != 2; i++) step();
        rst_n = 1'b0;
        #1;
        checks++; if (ddr_d0 !== 4'b0000 || ddr_d1 !== 4'b0000) begin
            errors++; $display("FAIL midrst_out: got d0=%b d1=%b want 0000/0000", ddr_d0, ddr_d1);
        end
        checks++; if (underflow_cnt !== 16'h0000) begin errors++; $display("FAIL midrst_cnt: got %h want 0000", underflow_cnt); end
        checks++; if (pixel_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick: got %b want 0", pixel_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (ddr_d0 !== 4'b1000 || ddr_d1 !== 4'b1000) begin
            errors++; $display("FAIL midrst_first: got d0=%b d1=%b want 1000/1000", ddr_d0, ddr_d1);
        end
        repeat (3) step();
        checks++; if (pixel_tick !== 1'b1) begin errors++; $display("FAIL midrst_slot: got %b want 1", pixel_tick); end
        step();
        checks++; if (rx_q[0] !== idle_word) begin errors++; $display("FAIL midrst_sym: got %h want %h", rx_q[0], idle_word); end
        repeat (5) step();
        checks++; if (rx_q[1] !== {CLKP, 10'h0F0, 10'h3C3, 10'h155}) begin
            errors++; $display("FAIL midrst_resume: got %h want %h", rx_q[1], {CLKP, 10'h0F0, 10'h3C3, 10'h155});
        end
        en = 1'b0;
        sym_valid = 1'b0;
    endtask

    initial begin
        idle_word = {CLKP, IDLE, IDLE, IDLE};
        test_reset();
        test_single_transfer();
        test_back_to_back();
        test_underflow();
        test_clear_race();
        test_disabled();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
